// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Owns the PC, drives the word-indexed instruction memory address, and queues the
// returned {pc, inst} pairs for decode through a valid/ready handshake. A redirect
// flushes the queue and reloads the PC; halt stops new fetches while the queue drains.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   imem_addr / imem_inst      word index out, instruction word back (same cycle)
//   halt                       suppress new fetches
//   redirect_valid/_pc         flush queue and load a new PC
//   out_valid/ready/inst/pc    queue head toward decode (registered outputs)
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);

    localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CntW = $clog2(QDEPTH) + 1;

    logic [31:0]     pc_q, pc_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [31:0]     q_pc_q   [QDEPTH];
    logic [31:0]     q_inst_q [QDEPTH];

    logic push;
    logic pop;

    // Low PC bits are always zero and the redirect target's low bits are dropped.
    logic unused_bits;
    assign unused_bits = ^{redirect_pc[1:0], pc_q[1:0]};

    assign imem_addr = {2'b00, pc_q[31:2]};

    assign out_valid = (count_q != '0);
    assign out_inst  = out_valid ? q_inst_q[rd_ptr_q] : 32'h0;
    assign out_pc    = out_valid ? q_pc_q[rd_ptr_q]   : 32'h0;

    assign pop  = out_valid & out_ready;
    // A full queue can still accept a push when the head leaves this cycle.
    assign push = ~redirect_valid & ~halt & ((count_q < CntW'(QDEPTH)) | pop);

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally since QDEPTH is a power of two.
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
                pc_d     = pc_q + 32'd4;
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: the count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc_q[wr_ptr_q]   <= pc_q;
            q_inst_q[wr_ptr_q] <= imem_inst;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        halt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    int checks;
    int failures;

    localparam logic [31:0] InstA = 32'h1111_000A;
    localparam logic [31:0] InstB = 32'h2222_000B;
    localparam logic [31:0] InstC = 32'h3333_000C;
    localparam logic [31:0] InstD = 32'h4444_000D;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model, indexed by word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'd0:   return InstA;
            32'd1:   return InstB;
            32'd2:   return InstC;
            32'd3:   return InstD;
            default: return 32'h5A00_0000 ^ a;
        endcase
    endfunction

    assign imem_inst = mem_word(imem_addr);

    // Advance one edge; outputs are sampled and inputs changed 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        rst_n          = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = ready;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        checks++;
        if ({out_valid, out_pc, out_inst} !== {1'b0, 32'h0, 32'h0}) begin
            failures++;
            $display("FAIL reset_outputs got v=%b pc=%h inst=%h want v=0 pc=0 inst=0",
                     out_valid, out_pc, out_inst);
        end
        checks++;
        if (imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_imem_addr got %h want 00000000", imem_addr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_inst [4];
        exp_inst[0] = InstA; exp_inst[1] = InstB; exp_inst[2] = InstC; exp_inst[3] = InstD;
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({out_valid, out_pc, out_inst} !== {1'b1, 32'(i * 4), exp_inst[i]}) begin
                failures++;
                $display("FAIL stream_%0d got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                         i, out_valid, out_pc, out_inst, 32'(i * 4), exp_inst[i]);
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] exp_inst [3];
        exp_inst[0] = InstB; exp_inst[1] = InstC; exp_inst[2] = InstD;
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h0, InstA}) begin
                failures++;
                $display("FAIL bp_hold_%0d got v=%b pc=%h inst=%h want v=1 pc=0 inst=%h",
                         i, out_valid, out_pc, out_inst, InstA);
            end
        end
        // Queue full at two entries, so the PC sits at byte 8.
        checks++;
        if (imem_addr !== 32'd2) begin
            failures++;
            $display("FAIL bp_pc_hold got imem_addr=%h want 00000002", imem_addr);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({out_valid, out_pc, out_inst} !== {1'b1, 32'((i + 1) * 4), exp_inst[i]}) begin
                failures++;
                $display("FAIL bp_drain_%0d got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                         i, out_valid, out_pc, out_inst, 32'((i + 1) * 4), exp_inst[i]);
            end
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b1);
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0023;
        step();
        redirect_valid = 1'b0;
        checks++;
        if ({out_valid, out_pc, out_inst, imem_addr} !== {1'b0, 32'h0, 32'h0, 32'd8}) begin
            failures++;
            $display("FAIL redirect_flush got v=%b pc=%h inst=%h addr=%h want v=0 pc=0 inst=0 addr=8",
                     out_valid, out_pc, out_inst, imem_addr);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({out_valid, out_pc, out_inst} !==
                {1'b1, 32'h20 + 32'(i * 4), mem_word(32'd8 + 32'(i))}) begin
                failures++;
                $display("FAIL redirect_target_%0d got v=%b pc=%h inst=%h want pc=%h inst=%h",
                         i, out_valid, out_pc, out_inst, 32'h20 + 32'(i * 4),
                         mem_word(32'd8 + 32'(i)));
            end
        end
    endtask

    task automatic test_redirect_full_halt();
        do_reset(1'b0);
        step();
        step();
        halt           = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        checks++;
        if ({out_valid, out_pc} !== {1'b1, 32'h0}) begin
            failures++;
            $display("FAIL rfh_head_before got v=%b pc=%h want v=1 pc=0", out_valid, out_pc);
        end
        step();
        redirect_valid = 1'b0;
        checks++;
        if ({out_valid, imem_addr} !== {1'b0, 32'h10}) begin
            failures++;
            $display("FAIL rfh_flush got v=%b addr=%h want v=0 addr=10", out_valid, imem_addr);
        end
        step();
        checks++;
        if ({out_valid, imem_addr} !== {1'b0, 32'h10}) begin
            failures++;
            $display("FAIL rfh_halt_hold got v=%b addr=%h want v=0 addr=10", out_valid, imem_addr);
        end
        halt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({out_valid, out_pc, out_inst} !==
                {1'b1, 32'h40 + 32'(i * 4), mem_word(32'h10 + 32'(i))}) begin
                failures++;
                $display("FAIL rfh_restart_%0d got v=%b pc=%h inst=%h want pc=%h inst=%h",
                         i, out_valid, out_pc, out_inst, 32'h40 + 32'(i * 4),
                         mem_word(32'h10 + 32'(i)));
            end
        end
    endtask

    task automatic test_pc_wrap();
        do_reset(1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        checks++;
        if ({out_valid, imem_addr} !== {1'b0, 32'h3FFF_FFFF}) begin
            failures++;
            $display("FAIL wrap_addr got v=%b addr=%h want v=0 addr=3fffffff", out_valid, imem_addr);
        end
        step();
        checks++;
        if ({out_valid, out_pc, out_inst} !== {1'b1, 32'hFFFF_FFFC, mem_word(32'h3FFF_FFFF)}) begin
            failures++;
            $display("FAIL wrap_last got v=%b pc=%h inst=%h want pc=fffffffc inst=%h",
                     out_valid, out_pc, out_inst, mem_word(32'h3FFF_FFFF));
        end
        step();
        checks++;
        if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h0, InstA}) begin
            failures++;
            $display("FAIL wrap_zero got v=%b pc=%h inst=%h want pc=0 inst=%h",
                     out_valid, out_pc, out_inst, InstA);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        step();
        step();
        checks++;
        if ({out_valid, imem_addr} !== {1'b1, 32'd2}) begin
            failures++;
            $display("FAIL rmid_pre got v=%b addr=%h want v=1 addr=2", out_valid, imem_addr);
        end
        rst_n          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        out_ready      = 1'b1;
        step();
        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        checks++;
        if ({out_valid, out_pc, out_inst, imem_addr} !== {1'b0, 32'h0, 32'h0, 32'h0}) begin
            failures++;
            $display("FAIL rmid_reset got v=%b pc=%h inst=%h addr=%h want all 0",
                     out_valid, out_pc, out_inst, imem_addr);
        end
        step();
        checks++;
        if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h0, InstA}) begin
            failures++;
            $display("FAIL rmid_restart got v=%b pc=%h inst=%h want v=1 pc=0 inst=%h",
                     out_valid, out_pc, out_inst, InstA);
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        test_reset();
        test_stream();
        test_back_pressure();
        test_redirect();
        test_redirect_full_halt();
        test_pc_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the core. Owns the program counter, drives the word-indexed instruction memory read address, and captures the returned instruction word together with its PC into a small queue. Decode consumes the queue through a valid/ready handshake. Branch and jump resolution redirects the unit through a flush-and-reload port. The unit sits between the instruction memory (combinational, word-indexed read) and the decode stage.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be 4-byte aligned.
- `QDEPTH`, default 2: fetch queue entries, power of two, ≥ 2.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: synchronous, active-low reset, sampled on rising `clk`.
- `imem_addr` out 32: word index into instruction memory, `{2'b00, pc[31:2]}`.
- `imem_inst` in 32: instruction word returned combinationally for `imem_addr` in the same cycle.
- `halt` in 1: while high, no new fetch is pushed; the queue still drains.
- `redirect_valid` in 1: load a new PC and flush the queue this cycle.
- `redirect_pc` in 32: target byte address; bits [1:0] ignored.
- `out_valid` out 1: the queue head holds a valid instruction.
- `out_ready` in 1: decode accepts the head this cycle.
- `out_inst` out 32: instruction at the queue head; 0 when empty.
- `out_pc` out 32: byte PC of `out_inst`; 0 when empty.

## Operation
- State:
  - `pc` (32 bits).
  - Circular queue of `QDEPTH` entries {pc, inst}, with read pointer, write pointer and count (width `$clog2(QDEPTH)+1`).
- Pop: `pop = out_valid & out_ready`. Removes the head and advances the read pointer modulo `QDEPTH`.
- Push: `push = ~redirect_valid & ~halt & (count < QDEPTH | pop)`.
  - Writes {`pc`, `imem_inst`} at the write pointer.
  - Sets `pc <= pc + 32'd4`, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - A full queue accepts a push in the same cycle as a pop; count is unchanged.
- Count update: `count <= count + push - pop`.
- Redirect has priority over everything:
  - Queue count, read pointer and write pointer all go to 0.
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - No push occurs that cycle.
  - Any pop in the same cycle still counts as accepted by decode; the flush discards everything else.
- Halt:
  - `pc` holds and no push occurs.
  - Pops continue.
  - Redirect is still honoured during halt.
- Output: `out_valid = (count != 0)`. `out_inst` and `out_pc` come from the head entry, or 0 when the queue is empty. All three are driven purely from registers; there is no combinational path from `imem_inst` or `out_ready` to them.
- `imem_addr` is combinational from `pc` only.

## Timing
- Reset (`rst_n` low at an edge):
  - `pc = RESET_PC`, queue empty.
  - `out_valid = 0`, `out_inst = 0`, `out_pc = 0`.
  - `imem_addr = RESET_PC >> 2`.
  - Reset overrides redirect, push and pop.
- Reset asserted mid-stream discards all queued entries in that cycle.
- Fetch-to-output latency is 1 cycle. An instruction fetched in cycle N is visible at `out_*` in cycle N+1 if the queue was empty.
- Redirect-to-first-valid is 2 cycles:
  - Cycle R: redirect asserted.
  - Cycle R+1: `out_valid = 0`, and the fetch from `redirect_pc` occurs.
  - Cycle R+2: the target instruction is at `out_*`.
- Steady-state throughput is 1 instruction per cycle with `out_ready` held high.
- Back-pressure:
  - With `out_ready` low, the queue fills to `QDEPTH` and `pc` then holds.
  - `out_*` stay stable while `out_valid & ~out_ready`.
- Pointers wrap modulo `QDEPTH`. Count never exceeds `QDEPTH` and never underflows.

## Test plan
- Reset then stream:
  - Stimulus: memory words 0..3 = A, B, C, D; `out_ready = 1`; release reset.
  - Required: first cycle after release `out_valid = 0`, `imem_addr = 0`. Then (`out_pc`, `out_inst`) = (0, A), (4, B), (8, C), (12, D) on consecutive cycles.
- Back-pressure:
  - Stimulus: `out_ready = 0` for 5 cycles after the first valid.
  - Required: `out_pc = 0` and `out_inst = A` held; `pc` stops at 8 with count = 2. After `out_ready` rises, sequence 0, 4, 8, 12 with no gaps or duplicates.
- Redirect:
  - Stimulus: while streaming, assert `redirect_valid` with `redirect_pc = 32'h0000_0023`.
  - Required: next cycle `out_valid = 0`, `imem_addr = 8`. The following cycle `out_pc = 32'h20`. Nothing older than the redirect appears after it.
- Redirect during simultaneous full-queue pop and halt:
  - Stimulus: queue full with `halt = 1` and `out_ready = 1`; assert redirect.
  - Required: the head is consumed and the queue flushes. Once `halt` drops, output restarts at the redirect target.
- PC wrap:
  - Stimulus: redirect to 32'hFFFF_FFFC.
  - Required: `out_pc` shows FFFF_FFFC then 0.
- Reset mid-operation:
  - Stimulus: assert `rst_n = 0` with 2 entries queued, together with `redirect_valid`.
  - Required: next cycle `out_valid = 0`, `out_inst = 0`, `out_pc = 0`, `pc = RESET_PC`.
